vsi_op_issuer: RTL and testbench

//  Host-side initiator for the coprocessor operation interface. Buffers host vector ops
//  (op word + lmul + sew) in a show-ahead FIFO and presents them on vsi_op/vsi_op_valid,

---
 rtl/vector_cop_pkg.sv | 26 ++
 rtl/vsi_op_fifo.sv | 57 +++++
 rtl/vsi_op_issuer.sv | 102 ++++++++++
 tb/tb_vsi_op_issuer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_cop_pkg.sv
// Shared types for the host-to-coprocessor operation path: the queued op record
// and the fence sequencing states.
package vector_cop_pkg;

    typedef struct packed {
        logic [31:0] op;
        logic        lmul;
        logic        sew;
    } vsi_op_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        WAIT,
        DONE
    } fence_state_t;

    function automatic vsi_op_t make_op(input logic [31:0] op, input logic lmul, input logic sew);
        vsi_op_t o;
        o.op   = op;
        o.lmul = lmul;
        o.sew  = sew;
        return o;
    endfunction

endpackage

// File: rtl/vsi_op_fifo.sv
// Show-ahead FIFO of vsi_op_t records: the head entry is always visible on 'head'
// and is retired by 'pop'. Pointers carry an extra wrap bit to tell full from empty.
module vsi_op_fifo
    import vector_cop_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  vsi_op_t       wdata,
    input  logic          pop,
    output vsi_op_t       head,
    output logic          full,
    output logic          empty,
    output logic [PTR_W:0] count
);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    vsi_op_t        mem [DEPTH];

    logic do_push;
    logic do_pop;

    // Guard locally so a misbehaving caller can never corrupt the pointers.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: the storage is reset as well because the head slot drives the interface
    // directly; an unreset array would put X on vsi_op straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[PTR_W-1:0]] <= wdata;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vsi_op_issuer.sv
// Host-side initiator for the coprocessor op interface: queues host ops, issues them
// under vsi_op_ready backpressure and sequences a fence that waits for drain plus idle.
module vsi_op_issuer
    import vector_cop_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     vsi_clk,
    input  logic                     vsi_rst_n,
    input  logic [31:0]              host_op,
    input  logic                     host_lmul,
    input  logic                     host_sew,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic                     host_fence_req,
    output logic                     host_fence_done,
    output logic [31:0]              vsi_op,
    output logic                     vsi_lmul,
    output logic                     vsi_sew,
    output logic                     vsi_op_valid,
    input  logic                     vsi_op_ready,
    input  logic                     vsi_cop_idle,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [CNT_W-1:0]         issued_cnt
);

    localparam int Q_W = $clog2(DEPTH) + 1;

    fence_state_t   state;
    vsi_op_t        head;
    logic           full;
    logic           empty;
    logic [Q_W-1:0] count;
    logic           push;
    logic           pop;
    logic           last_hs;
    logic           drains_now;

    assign host_ready      = !full && (state == RUN);
    assign push            = host_valid && host_ready;
    assign vsi_op_valid    = !empty;
    assign pop             = vsi_op_valid && vsi_op_ready;
    assign host_fence_done = (state == DONE);

    assign vsi_op   = head.op;
    assign vsi_lmul = head.lmul;
    assign vsi_sew  = head.sew;
    assign q_count  = count;

    // True when the queue is empty after this edge; no push can occur outside RUN.
    assign drains_now = empty || ((count == Q_W'(1)) && pop);

    vsi_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (vsi_clk),
        .rst_n (vsi_rst_n),
        .push  (push),
        .wdata (make_op(host_op, host_lmul, host_sew)),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // NOTE: every register here uses <= so all of them sample pre-edge values;
    // last_hs in particular must see the pop of the previous cycle, not this one.
    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
        if (!vsi_rst_n) begin
            state      <= RUN;
            last_hs    <= 1'b0;
            issued_cnt <= '0;
        end else begin
            last_hs <= pop;
            if (pop) begin
                issued_cnt <= issued_cnt + 1'b1;
            end

            case (state)
                RUN: begin
                    if (host_fence_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (drains_now) state <= WAIT;
                end
                WAIT: begin
                    // The coprocessor's idle flag may not yet reflect an op taken last cycle.
                    if (vsi_cop_idle && !last_hs) state <= DONE;
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vsi_op_issuer.sv
// Directed bench for vsi_op_issuer: a scoreboard queue holds every accepted op and a
// monitor pops and compares each handshake on the coprocessor side.
module tb_vsi_op_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] host_op;
    logic        host_lmul;
    logic        host_sew;
    logic        host_valid;
    logic        host_ready;
    logic        host_fence_req;
    logic        host_fence_done;
    logic [31:0] vsi_op;
    logic        vsi_lmul;
    logic        vsi_sew;
    logic        vsi_op_valid;
    logic        vsi_op_ready;
    logic        vsi_cop_idle;
    logic [2:0]  q_count;
    logic [15:0] issued_cnt;

    int checks = 0;
    int errors = 0;
    int exp_issued = 0;
    logic [33:0] sb [$];

    vsi_op_issuer #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .vsi_clk         (clk),
        .vsi_rst_n       (rst_n),
        .host_op         (host_op),
        .host_lmul       (host_lmul),
        .host_sew        (host_sew),
        .host_valid      (host_valid),
        .host_ready      (host_ready),
        .host_fence_req  (host_fence_req),
        .host_fence_done (host_fence_done),
        .vsi_op          (vsi_op),
        .vsi_lmul        (vsi_lmul),
        .vsi_sew         (vsi_sew),
        .vsi_op_valid    (vsi_op_valid),
        .vsi_op_ready    (vsi_op_ready),
        .vsi_cop_idle    (vsi_cop_idle),
        .q_count         (q_count),
        .issued_cnt      (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one op and hold it until the issuer takes it; record it in the scoreboard.
    task automatic send(input logic [31:0] op, input logic lmul, input logic sew);
        host_op    = op;
        host_lmul  = lmul;
        host_sew   = sew;
        host_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (host_ready) break;
        end
        check("send_accept", 32'(host_ready), 32'd1);
        sb.push_back({op, lmul, sew});
        @(posedge clk);
        #1;
        host_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (q_count == 3'd0) break;
        end
        check({tag, "_drained"}, 32'(q_count), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Coprocessor-side monitor: every handshake must match the oldest accepted op.
    always @(negedge clk) begin
        if (rst_n && vsi_op_valid && vsi_op_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [33:0] e;
                e = sb.pop_front();
                check("pop_op", vsi_op, e[33:2]);
                check("pop_lmul", 32'(vsi_lmul), 32'(e[1]));
                check("pop_sew", 32'(vsi_sew), 32'(e[0]));
                check("pop_issued", 32'(issued_cnt), 32'(exp_issued));
                exp_issued++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        host_op        = '0;
        host_lmul      = 1'b0;
        host_sew       = 1'b0;
        host_valid     = 1'b0;
        host_fence_req = 1'b0;
        vsi_op_ready   = 1'b0;
        vsi_cop_idle   = 1'b1;

        // Reset state
        #12;
        check("rst_valid", 32'(vsi_op_valid), 32'd0);
        check("rst_ready", 32'(host_ready), 32'd1);
        check("rst_done", 32'(host_fence_done), 32'd0);
        check("rst_qcount", 32'(q_count), 32'd0);
        check("rst_issued", 32'(issued_cnt), 32'd0);
        check("rst_op", vsi_op, 32'd0);
        check("rst_lmul_sew", 32'({vsi_lmul, vsi_sew}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single op: visible one cycle after the push, then taken
        vsi_op_ready = 1'b1;
        send(32'h0000_00AB, 1'b1, 1'b0);
        check("t1_valid", 32'(vsi_op_valid), 32'd1);
        check("t1_op", vsi_op, 32'h0000_00AB);
        check("t1_lmul", 32'(vsi_lmul), 32'd1);
        check("t1_sew", 32'(vsi_sew), 32'd0);
        @(posedge clk);
        #1;
        check("t1_valid_after", 32'(vsi_op_valid), 32'd0);
        check("t1_qcount", 32'(q_count), 32'd0);
        check("t1_issued", 32'(issued_cnt), 32'd1);

        // Fill under backpressure, fifth op held by the host
        vsi_op_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            logic [31:0] v;
            v = 32'(i);
            send(32'h0000_0100 + v, v[0], v[1]);
        end
        check("t2_full_count", 32'(q_count), 32'd4);
        check("t2_full_ready", 32'(host_ready), 32'd0);
        host_op    = 32'h0000_0105;
        host_lmul  = 1'b1;
        host_sew   = 1'b0;
        host_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t2_hold_valid", 32'(vsi_op_valid), 32'd1);
            check("t2_hold_op", vsi_op, 32'h0000_0101);
            check("t2_hold_fields", 32'({vsi_lmul, vsi_sew}), 32'b10);
            check("t2_hold_count", 32'(q_count), 32'd4);
        end
        vsi_op_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (host_ready) break;
        end
        check("t2_fifth_accept", 32'(host_ready), 32'd1);
        sb.push_back({32'h0000_0105, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        wait_drain("t2");
        check("t2_issued", 32'(issued_cnt), 32'd6);

        // Simultaneous push and pop at occupancy 2
        vsi_op_ready = 1'b0;
        send(32'h0000_0201, 1'b0, 1'b1);
        send(32'h0000_0202, 1'b1, 1'b1);
        check("t3_start_count", 32'(q_count), 32'd2);
        vsi_op_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] v;
            v          = 32'h0000_0300 + 32'(i);
            host_op    = v;
            host_lmul  = v[0];
            host_sew   = 1'b0;
            host_valid = 1'b1;
            @(negedge clk);
            check("t3_ready", 32'(host_ready), 32'd1);
            if (host_ready) sb.push_back({v, v[0], 1'b0});
            @(posedge clk);
            #1;
            check("t3_count", 32'(q_count), 32'd2);
        end
        host_valid = 1'b0;
        wait_drain("t3");

        // Fence held off by a busy coprocessor; push in the request cycle still lands
        vsi_op_ready = 1'b0;
        vsi_cop_idle = 1'b0;
        send(32'h0000_0401, 1'b0, 1'b0);
        send(32'h0000_0402, 1'b1, 1'b0);
        host_fence_req = 1'b1;
        send(32'h0000_0403, 1'b0, 1'b1);
        host_fence_req = 1'b0;
        check("t4_count", 32'(q_count), 32'd3);
        check("t4_ready_blocked", 32'(host_ready), 32'd0);
        vsi_op_ready = 1'b1;
        wait_drain("t4");
        for (int i = 0; i < 3; i++) begin
            check("t4_no_done_busy", 32'(host_fence_done), 32'd0);
            check("t4_ready_still_blocked", 32'(host_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        vsi_cop_idle = 1'b1;
        @(posedge clk);
        #1;
        check("t4_done", 32'(host_fence_done), 32'd1);
        @(posedge clk);
        #1;
        check("t4_done_single", 32'(host_fence_done), 32'd0);
        check("t4_ready_back", 32'(host_ready), 32'd1);

        // Fence with nothing queued: DRAIN and WAIT take one cycle each, then DONE
        host_fence_req = 1'b1;
        @(posedge clk);
        #1;
        host_fence_req = 1'b0;
        check("t5a_drain_done", 32'(host_fence_done), 32'd0);
        check("t5a_drain_ready", 32'(host_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t5a_wait_done", 32'(host_fence_done), 32'd0);
        @(posedge clk);
        #1;
        check("t5a_done", 32'(host_fence_done), 32'd1);
        @(posedge clk);
        #1;
        check("t5a_done_single", 32'(host_fence_done), 32'd0);
        check("t5a_ready_back", 32'(host_ready), 32'd1);

        // Fence where the final pop coincides with idle: one extra cycle before DONE
        vsi_op_ready = 1'b0;
        send(32'h0000_0501, 1'b1, 1'b1);
        host_fence_req = 1'b1;
        @(posedge clk);
        #1;
        host_fence_req = 1'b0;
        vsi_op_ready   = 1'b1;
        @(posedge clk);
        #1;
        check("t5b_popped", 32'(q_count), 32'd0);
        check("t5b_no_done_pop", 32'(host_fence_done), 32'd0);
        @(posedge clk);
        #1;
        check("t5b_no_done_guard", 32'(host_fence_done), 32'd0);
        @(posedge clk);
        #1;
        check("t5b_done", 32'(host_fence_done), 32'd1);
        @(posedge clk);
        #1;
        check("t5b_done_single", 32'(host_fence_done), 32'd0);
        check("t5b_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a drain
        vsi_op_ready = 1'b0;
        vsi_cop_idle = 1'b0;
        send(32'h0000_0601, 1'b0, 1'b0);
        send(32'h0000_0602, 1'b0, 1'b1);
        send(32'h0000_0603, 1'b1, 1'b0);
        host_fence_req = 1'b1;
        @(posedge clk);
        #1;
        host_fence_req = 1'b0;
        check("t6_pre_count", 32'(q_count), 32'd3);
        check("t6_pre_valid", 32'(vsi_op_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(vsi_op_valid), 32'd0);
        check("t6_async_done", 32'(host_fence_done), 32'd0);
        sb.delete();
        exp_issued = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_count", 32'(q_count), 32'd0);
        check("t6_issued", 32'(issued_cnt), 32'd0);
        check("t6_ready", 32'(host_ready), 32'd1);
        check("t6_valid", 32'(vsi_op_valid), 32'd0);

        // Normal traffic resumes after the reset
        vsi_op_ready = 1'b1;
        vsi_cop_idle = 1'b1;
        send(32'hCAFE_0001, 1'b1, 1'b1);
        wait_drain("t6_post");
        check("t6_post_issued", 32'(issued_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
